// File: rtl/core_defs.sv
// Shared core definitions: hazard-controller state encoding and pipeline constants.
package core_defs;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLuStall  = 2'd1,
        StMcWait   = 2'd2,
        StJmpFlush = 2'd3
    } state_e;

    localparam logic [31:0]  NOP_INSN       = 32'h0000_0013;
    localparam int unsigned  MC_TIMEOUT_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush generation for PC, IF/ID and ID/EX
// covering taken jumps, load-use hazards and multi-cycle EX operations.
module pipe_ctrl
    import core_defs::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              ld_use,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              pc_jump_en,
    output logic [ADDR_W-1:0] pc_jump_addr,
    output logic              mc_timeout,
    output logic              busy
);

    localparam int unsigned          CNT_W  = $clog2(MC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_TO = CNT_W'(MC_TIMEOUT);

    state_e             r_state;
    state_e             w_next;
    logic [ADDR_W-1:0]  r_jaddr;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_load;
    logic               w_cnt_inc;
    logic               w_spc, w_sif, w_sie, w_fif, w_fie, w_jen, w_mto;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_inc      (w_cnt_inc),
        .o_count    (w_cnt)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_inc  = 1'b0;
        w_spc      = 1'b0;
        w_sif      = 1'b0;
        w_sie      = 1'b0;
        w_fif      = 1'b0;
        w_fie      = 1'b0;
        w_jen      = 1'b0;
        w_mto      = 1'b0;
        // Outputs are forced low while reset is held, independent of inputs.
        if (rst) begin
            unique case (r_state)
                StRun: begin
                    if (jump_req) begin
                        w_jen  = 1'b1;
                        w_fif  = 1'b1;
                        w_fie  = 1'b1;
                        w_next = StJmpFlush;
                    end else if (mc_start) begin
                        w_spc      = 1'b1;
                        w_sif      = 1'b1;
                        w_sie      = 1'b1;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = CNT_W'(1);
                        w_next     = StMcWait;
                    end else if (ld_use) begin
                        w_spc  = 1'b1;
                        w_sif  = 1'b1;
                        w_fie  = 1'b1;
                        w_next = StLuStall;
                    end
                end
                StLuStall: begin
                    // ld_use deliberately ignored here to break stall livelock.
                    if (jump_req) begin
                        w_jen  = 1'b1;
                        w_fif  = 1'b1;
                        w_fie  = 1'b1;
                        w_next = StJmpFlush;
                    end else begin
                        w_next = StRun;
                    end
                end
                StMcWait: begin
                    if (mc_done) begin
                        w_cnt_load = 1'b1;
                        w_next     = StRun;
                    end else if (w_cnt == CNT_TO) begin
                        w_mto      = 1'b1;
                        w_fie      = 1'b1;
                        w_cnt_load = 1'b1;
                        w_next     = StRun;
                    end else begin
                        w_spc     = 1'b1;
                        w_sif     = 1'b1;
                        w_sie     = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
                StJmpFlush: begin
                    w_fif = 1'b1;
                    if (jump_req) begin
                        w_jen  = 1'b1;
                        w_fie  = 1'b1;
                        w_next = StJmpFlush;
                    end else begin
                        w_next = StRun;
                    end
                end
                default: w_next = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StRun;
            r_jaddr <= '0;
        end else begin
            r_state <= w_next;
            r_jaddr <= jump_addr;
        end
    end

    // Flush overrides stall on the same pipeline register.
    assign stall_pc     = w_spc;
    assign stall_if_id  = w_sif & ~w_fif;
    assign stall_id_ex  = w_sie & ~w_fie;
    assign flush_if_id  = w_fif;
    assign flush_id_ex  = w_fie;
    assign pc_jump_en   = w_jen;
    assign pc_jump_addr = w_jen ? jump_addr : r_jaddr;
    assign mc_timeout   = w_mto;
    assign busy         = (r_state != StRun);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table through a scoreboard queue, plus timeout and
// mid-operation reset sequences on two instances with different timeouts.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req, ld_use, mc_start, mc_done;
    logic [31:0] jump_addr;

    logic        a_spc, a_sif, a_sie, a_fif, a_fie, a_jen, a_mto, a_busy;
    logic [31:0] a_addr;
    logic        b_spc, b_sif, b_sie, b_fif, b_fie, b_jen, b_mto, b_busy;
    logic [31:0] b_addr;
    logic [7:0]  a_ctl, b_ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(32), .MC_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .jump_req(jump_req), .jump_addr(jump_addr),
        .ld_use(ld_use), .mc_start(mc_start), .mc_done(mc_done),
        .stall_pc(a_spc), .stall_if_id(a_sif), .stall_id_ex(a_sie),
        .flush_if_id(a_fif), .flush_id_ex(a_fie), .pc_jump_en(a_jen),
        .pc_jump_addr(a_addr), .mc_timeout(a_mto), .busy(a_busy)
    );

    pipe_ctrl #(.ADDR_W(32), .MC_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .jump_req(jump_req), .jump_addr(jump_addr),
        .ld_use(ld_use), .mc_start(mc_start), .mc_done(mc_done),
        .stall_pc(b_spc), .stall_if_id(b_sif), .stall_id_ex(b_sie),
        .flush_if_id(b_fif), .flush_id_ex(b_fie), .pc_jump_en(b_jen),
        .pc_jump_addr(b_addr), .mc_timeout(b_mto), .busy(b_busy)
    );

    // {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, pc_jump_en, mc_timeout, busy}
    assign a_ctl = {a_spc, a_sif, a_sie, a_fif, a_fie, a_jen, a_mto, a_busy};
    assign b_ctl = {b_spc, b_sif, b_sie, b_fif, b_fie, b_jen, b_mto, b_busy};

    typedef struct {
        logic        jr;
        logic [31:0] ja;
        logic        ld;
        logic        mc;
        logic        md;
        logic [7:0]  ctl;
    } vec_t;

    typedef struct {
        int          idx;
        logic [7:0]  ctl;
        logic [31:0] addr;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] prev_ja;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got ctl=%b addr=%h, want ctl=%b addr=%h",
                     name, act[39:32], act[31:0], req[39:32], req[31:0]);
        end
    endtask

    task automatic add(input logic jr, input logic [31:0] ja, input logic ld,
                       input logic mc, input logic md, input logic [7:0] ctl);
        vec_t v;
        v.jr = jr; v.ja = ja; v.ld = ld; v.mc = mc; v.md = md; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        jump_req = 1'b0; jump_addr = '0; ld_use = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        prev_ja = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", {a_ctl, a_addr}, 40'h0);
        chk("reset_b", {b_ctl, b_addr}, 40'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        jump_req = v.jr; jump_addr = v.ja; ld_use = v.ld; mc_start = v.mc; mc_done = v.md;
        e.idx  = idx;
        e.ctl  = v.ctl;
        e.addr = v.ctl[2] ? v.ja : prev_ja;
        sb.push_back(e);
        prev_ja = v.ja;
        @(negedge clk);
        got = sb.pop_front();
        chk($sformatf("vec%0d", got.idx), {a_ctl, a_addr}, {got.ctl, got.addr});
    endtask

    initial begin
        logic [7:0] ea, eb;

        // jr, ja, ld, mc, md, expected ctl
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);  // idle
        add(1, 32'h100,   0, 0, 0, 8'b0001_1100);  // jump in RUN
        add(0, 32'h0,     0, 0, 0, 8'b0001_0001);  // JMP_FLUSH, addr held
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(0, 32'h0,     1, 0, 0, 8'b1100_1000);  // load-use
        add(0, 32'h0,     1, 0, 0, 8'b0000_0001);  // LU_STALL ignores ld_use
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(0, 32'h0,     0, 0, 1, 8'b0000_0000);  // stray mc_done
        add(1, 32'h200,   1, 1, 0, 8'b0001_1100);  // priority: jump wins
        add(0, 32'h0,     1, 1, 0, 8'b0001_0001);
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(1, 32'h300,   0, 0, 0, 8'b0001_1100);
        add(1, 32'h400,   0, 0, 0, 8'b0001_1101);  // jump inside JMP_FLUSH
        add(0, 32'h0,     0, 0, 0, 8'b0001_0001);
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(0, 32'h0,     1, 0, 0, 8'b1100_1000);
        add(1, 32'h500,   0, 0, 0, 8'b0001_1101);  // jump inside LU_STALL
        add(0, 32'h0,     0, 0, 0, 8'b0001_0001);
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(0, 32'h0,     0, 1, 1, 8'b1110_0000);  // start+done: start only
        add(0, 32'h0,     0, 0, 1, 8'b0000_0001);
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);
        add(0, 32'h0,     0, 1, 0, 8'b1110_0000);  // 5-cycle multi-cycle op
        add(0, 32'h0,     0, 0, 0, 8'b1110_0001);
        add(1, 32'h600,   1, 0, 0, 8'b1110_0001);  // jump ignored in MC_WAIT
        add(0, 32'h0,     0, 0, 0, 8'b1110_0001);
        add(0, 32'h0,     0, 0, 0, 8'b1110_0001);
        add(0, 32'h0,     0, 0, 1, 8'b0000_0001);
        add(0, 32'h0,     0, 0, 0, 8'b0000_0000);

        do_reset();
        foreach (tbl[i]) apply(i, tbl[i]);

        // Timeout: dut_a aborts after 8 stalled cycles, dut_b after 4.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            mc_start = (k == 0);
            @(negedge clk);
            if (k < 8)       ea = {3'b111, 4'b0000, (k > 0)};
            else if (k == 8) ea = 8'b0000_1011;
            else             ea = 8'b0000_0000;
            if (k < 4)       eb = {3'b111, 4'b0000, (k > 0)};
            else if (k == 4) eb = 8'b0000_1011;
            else             eb = 8'b0000_0000;
            chk($sformatf("timeout_a_c%0d", k), {a_ctl, a_addr}, {ea, 32'h0});
            chk($sformatf("timeout_b_c%0d", k), {b_ctl, b_addr}, {eb, 32'h0});
        end

        // Reset asserted while stalled in MC_WAIT.
        @(posedge clk); #1; mc_start = 1'b1;
        @(posedge clk); #1; mc_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_pre", {a_ctl, a_addr}, {8'b1110_0001, 32'h0});
        #1 rst = 1'b0;
        #1;
        chk("midrst_async_a", {a_ctl, a_addr}, 40'h0);
        chk("midrst_async_b", {b_ctl, b_addr}, 40'h0);
        chk("midrst_cnt", {37'h0, dut_a.w_cnt}, 40'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_run", {a_ctl, a_addr}, 40'h0);
        chk("midrst_cnt_post", {37'h0, dut_a.w_cnt}, 40'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the in-order RISC-V core. It generates the per-stage stall and flush controls for the PC, IF/ID and ID/EX registers. It resolves three events: taken jumps/branches from EX, load-use hazards detected in ID, and multi-cycle EX operations (divider). Flush outputs drive the existing `hold` inputs of the pipeline registers, which reload their NOP/zero values (ID/EX instruction becomes 32'h13).

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- MC_TIMEOUT, 64, max cycles to wait for a multi-cycle op before abort (≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- jump_req  in  1  EX resolved taken jump/branch this cycle
- jump_addr  in  ADDR_W  EX jump target
- ld_use  in  1  ID: instruction in EX is a load whose rd matches an ID source
- mc_start  in  1  EX issues a multi-cycle op this cycle
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- stall_pc  out  1  freeze PC
- stall_if_id  out  1  freeze IF/ID
- stall_id_ex  out  1  freeze ID/EX
- flush_if_id  out  1  load NOP into IF/ID
- flush_id_ex  out  1  load NOP into ID/EX
- pc_jump_en  out  1  PC loads pc_jump_addr next edge
- pc_jump_addr  out  ADDR_W  PC redirect target
- mc_timeout  out  1  1-cycle pulse: multi-cycle op aborted
- busy  out  1  state ≠ RUN

## Operation
- States: RUN, LU_STALL, MC_WAIT, JMP_FLUSH.
- RUN:
  - jump_req: pc_jump_en=1, pc_jump_addr=jump_addr, flush_if_id=1, flush_id_ex=1 in the same cycle; next state JMP_FLUSH.
  - else mc_start: stall_pc, stall_if_id, stall_id_ex=1; counter loaded with 1; next state MC_WAIT.
  - else ld_use: stall_pc=1, stall_if_id=1, flush_id_ex=1; next state LU_STALL.
  - else all outputs 0.
- Priority in RUN is jump > mc_start > ld_use. Losers are ignored; the flush or refetch regenerates them if still valid.
- LU_STALL: lasts exactly one cycle. All controls are 0, and ld_use is ignored this cycle so a livelock cannot occur. Next state RUN. If jump_req is seen here, it is handled as in RUN.
- MC_WAIT: stall_pc, stall_if_id, stall_id_ex held at 1. Counter increments each cycle.
  - mc_done: stalls drop in that same cycle; next state RUN.
  - counter == MC_TIMEOUT without mc_done: mc_timeout=1, stalls drop, flush_id_ex=1; next state RUN.
  - jump_req is ignored in MC_WAIT, because EX is occupied.
- JMP_FLUSH: one cycle. flush_if_id=1 discards the wrong-path fetch already in flight. pc_jump_en=0. Next state RUN. A jump_req here is taken as in RUN and remains in JMP_FLUSH.
- Flush and stall of the same register are never asserted together. If both would apply, flush wins.
- pc_jump_addr is a registered copy of jump_addr while pc_jump_en=0, and a pass-through while pc_jump_en=1.

## Timing
- Reset (rst=0, async): state RUN, counter 0, pc_jump_addr 0, and every output 0.
- All control outputs are combinational from state and inputs (Mealy) and are valid in the cycle of the triggering input. State and counter update on the rising clk edge.
- Jump penalty: 2 bubbles (the cycle of jump_req plus JMP_FLUSH).
- Load-use penalty: 1 bubble.
- Multi-cycle stall: N cycles, where mc_done arrives N cycles after mc_start.
- Counter width: clog2(MC_TIMEOUT+1). The counter saturates and never wraps.
- mc_done in RUN (stray) is ignored.
- mc_start and mc_done in the same cycle in RUN: treated as mc_start only.
- Reset asserted mid-stall aborts immediately to RUN with all outputs 0 and no mc_timeout pulse.

## Structure
- The shared core package (`core_defs`) holds:
  - the state enum encoding (2 bits)
  - NOP_INSN = 32'h13
  - the default MC_TIMEOUT value
- One sub-module, `sat_counter`, is natural: a parameterized saturating up-counter with load, used for the timeout. All other logic is flat.
- The state register uses the codebase's `dff_set`-style async-reset flop behaviour with active-low reset.

## Test plan
- Jump: jump_req=1 with jump_addr=32'h0000_0100 in RUN. Same cycle: pc_jump_en=1, pc_jump_addr=0x100, both flushes=1. Next cycle: only flush_if_id=1. Then all 0.
- Load-use: ld_use=1 for 2 consecutive cycles. Cycle 1: stall_pc=stall_if_id=flush_id_ex=1. Cycle 2: all 0 (LU_STALL). Then RUN.
- Multi-cycle op: mc_start, then mc_done 5 cycles later. Stalls are 1 for exactly 5 cycles, including the mc_start cycle, and 0 in the mc_done cycle.
- Timeout: MC_TIMEOUT=4, mc_start, no mc_done. Stalls hold for 4 cycles, then mc_timeout and flush_id_ex pulse for 1 cycle, then busy=0.
- Priority: jump_req, mc_start and ld_use all 1 in RUN. Only the jump response occurs and the next state is JMP_FLUSH. Jump_req during MC_WAIT produces no pc_jump_en.
- Reset mid-operation: rst=0 in MC_WAIT. All outputs are 0 asynchronously, before the next edge. After release the block is in RUN and the counter is 0.
